// File: rtl/wisc_pkg.sv
// Shared types and default widths for the memory-port arbiter slice.
package wisc_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    HALTED  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data, halt and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the pipeline-plus-memory side.
interface mem_port_arbiter_if
  import wisc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_valid;
  logic              d_re;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              halt_req;
  logic              halted;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              err_rw;

  modport slave (
    input  if_req, if_addr, d_re, d_we, d_addr, d_wdata, halt_req, mem_rdata, mem_rdy,
    output if_data, if_valid, d_rdata, d_done, halted, mem_addr, mem_wdata, mem_re, mem_we,
           err_rw
  );

  modport master (
    output if_req, if_addr, d_re, d_we, d_addr, d_wdata, halt_req, mem_rdata, mem_rdy,
    input  if_data, if_valid, d_rdata, d_done, halted, mem_addr, mem_wdata, mem_re, mem_we,
           err_rw
  );

endinterface

// File: rtl/arb_fair_cnt.sv
// Saturating count of consecutive data grants made while a fetch waits.
module arb_fair_cnt #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt;

  // Count up on inc, stop at MAX; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and the data path, one
// outstanding access at a time, data first with bounded fetch starvation,
// and an orderly drain-and-stop on HALT.
module mem_port_arbiter
  import wisc_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_D_RUN = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_D_RUN + 1);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] fetch_word;
  logic [DATA_W-1:0] load_word;
  logic              acc_wr;
  logic              fetch_pulse;
  logic              data_pulse;
  logic              halt_seen;
  logic              rw_err;
  logic              data_req, halt_eff, fetch_ok, data_pick;
  logic              busy, done, grant_d, grant_f;
  logic              fcnt_inc, fcnt_clr, fcnt_sat;

  assign data_req  = bus.d_re | bus.d_we;
  assign halt_eff  = halt_seen | bus.halt_req;
  // Once halt is seen a fetch can never be granted, so it stops competing for
  // fairness; otherwise a saturated counter plus halt would stall data forever.
  assign fetch_ok  = bus.if_req & ~halt_eff;
  assign data_pick = data_req & (~fcnt_sat | ~fetch_ok);
  assign busy      = (state == IF_BUSY) | (state == D_BUSY);
  assign done      = busy & bus.mem_rdy;
  assign grant_d   = (state == IDLE) & (state_nxt == D_BUSY);
  assign grant_f   = (state == IDLE) & (state_nxt == IF_BUSY);
  assign fcnt_inc  = grant_d & bus.if_req;
  assign fcnt_clr  = grant_f | ((state == IDLE) & ~bus.if_req);

  arb_fair_cnt #(
    .MAX (MAX_D_RUN),
    .W   (CNT_W)
  ) u_fair_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fcnt_inc),
    .clr   (fcnt_clr),
    .sat   (fcnt_sat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: arbitration in IDLE, wait for mem_rdy while busy, HALTED is terminal.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (data_pick) begin
          state_nxt = D_BUSY;
        end else if (fetch_ok) begin
          state_nxt = IF_BUSY;
        end else if (halt_eff) begin
          state_nxt = HALTED;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (bus.mem_rdy) begin
          state_nxt = IDLE;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and halted decoded from state; write/read choice fixed at grant.
  always_comb begin
    bus.mem_re = 1'b0;
    bus.mem_we = 1'b0;
    bus.halted = 1'b0;
    case (state)
      IF_BUSY: bus.mem_re = 1'b1;
      D_BUSY: begin
        bus.mem_re = ~acc_wr;
        bus.mem_we = acc_wr;
      end
      HALTED:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  // Access registers: address/data latched on grant, read data captured on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_addr    <= '0;
      acc_wdata   <= '0;
      acc_wr      <= 1'b0;
      fetch_word  <= '0;
      load_word   <= '0;
      fetch_pulse <= 1'b0;
      data_pulse  <= 1'b0;
    end else begin
      fetch_pulse <= done & (state == IF_BUSY);
      data_pulse  <= done & (state == D_BUSY);
      if (grant_d) begin
        acc_addr  <= bus.d_addr;
        acc_wdata <= bus.d_wdata;
        acc_wr    <= bus.d_we;
      end else if (grant_f) begin
        acc_addr  <= bus.if_addr;
        acc_wdata <= '0;
        acc_wr    <= 1'b0;
      end
      if (done && (state == IF_BUSY)) begin
        fetch_word <= bus.mem_rdata;
      end
      if (done && (state == D_BUSY) && !acc_wr) begin
        load_word <= bus.mem_rdata;
      end
    end
  end

  // Sticky flags: halt latch and simultaneous read+write error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_seen <= 1'b0;
      rw_err    <= 1'b0;
    end else begin
      halt_seen <= halt_seen | bus.halt_req;
      rw_err    <= rw_err | (bus.d_re & bus.d_we & (state != HALTED));
    end
  end

  assign bus.mem_addr  = acc_addr;
  assign bus.mem_wdata = acc_wdata;
  assign bus.if_data   = fetch_word;
  assign bus.if_valid  = fetch_pulse;
  assign bus.d_rdata   = load_word;
  assign bus.d_done    = data_pulse;
  assign bus.err_rw    = rw_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expectations, a monitor
// on the falling edge pops and compares whenever the DUT presents a result.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXR = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct { bit rd; logic [15:0] data; } dexp_t;
  typedef struct { logic [15:0] addr; bit we; logic [15:0] wdata; } bexp_t;

  logic [15:0] if_exp[$];
  dexp_t       d_exp[$];
  bexp_t       ifb_exp[$];
  bexp_t       db_exp[$];
  logic [15:0] mem[int];
  logic [15:0] ref_mem[int];

  int    checks = 0;
  int    failures = 0;
  int    lat_fixed = -1;
  int    wait_cnt = -1;
  bit    fair_chk = 1'b1;
  int    run = 0;
  int    if_vld_cnt = 0;
  int    d_done_cnt = 0;
  string gs = "";
  bit    strobe_prev = 1'b0;
  logic  ifr_e = 1'b0, dr_e = 1'b0, busy_e = 1'b0, halted_e = 1'b0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Memory model: answers the active strobe after lat_fixed (or random 0..3) extra cycles.
  initial begin
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rdy = 1'b0;
      if (bus.mem_re || bus.mem_we) begin
        if (wait_cnt < 0) wait_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        if (wait_cnt == 0) begin
          bus.mem_rdy = 1'b1;
          if (bus.mem_we) begin
            mem[int'(bus.mem_addr)] = bus.mem_wdata;
            bus.mem_rdata = 16'($urandom);
          end else begin
            bus.mem_rdata = mem_rd(bus.mem_addr);
          end
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end else begin
        wait_cnt = -1;
      end
    end
  end

  // Request and status levels as seen by each active edge.
  initial begin
    forever begin
      @(posedge clk);
      ifr_e    = bus.if_req;
      dr_e     = bus.d_re | bus.d_we;
      busy_e   = bus.mem_re | bus.mem_we;
      halted_e = bus.halted;
    end
  end

  // Monitor: completions, memory-side grants and the fairness/priority rules.
  initial begin
    dexp_t de;
    bexp_t be;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        strobe_prev = 1'b0;
        run = 0;
      end else begin
        if (bus.if_valid) begin
          if_vld_cnt++;
          if (if_exp.size() == 0) chk("if_valid_unexpected", 32'(bus.if_valid), 32'd0);
          else chk("if_data", 32'(bus.if_data), 32'(if_exp.pop_front()));
        end
        if (bus.d_done) begin
          d_done_cnt++;
          if (d_exp.size() == 0) chk("d_done_unexpected", 32'(bus.d_done), 32'd0);
          else begin
            de = d_exp.pop_front();
            if (de.rd) chk("d_rdata", 32'(bus.d_rdata), 32'(de.data));
          end
        end
        if ((bus.mem_re || bus.mem_we) && !strobe_prev) begin
          if (bus.mem_we || bus.mem_addr >= 16'h1000) begin
            gs = {gs, "D"};
            if (db_exp.size() == 0) chk("d_grant_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            else begin
              be = db_exp.pop_front();
              chk("d_bus_addr", 32'(bus.mem_addr), 32'(be.addr));
              chk("d_bus_we", 32'(bus.mem_we), 32'(be.we));
              chk("d_bus_re", 32'(bus.mem_re), 32'(!be.we));
              if (be.we) chk("d_bus_wdata", 32'(bus.mem_wdata), 32'(be.wdata));
            end
            if (fair_chk) begin
              if (ifr_e) begin
                chk("fair_run_below_max", 32'(run < MAXR), 32'd1);
                run++;
              end else begin
                run = 0;
              end
            end
          end else begin
            gs = {gs, "F"};
            if (ifb_exp.size() == 0) chk("f_grant_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            else begin
              be = ifb_exp.pop_front();
              chk("f_bus_addr", 32'(bus.mem_addr), 32'(be.addr));
              chk("f_bus_re", 32'(bus.mem_re), 32'd1);
            end
            if (fair_chk && dr_e) chk("fetch_over_data_run", 32'(run), 32'(MAXR));
            run = 0;
          end
        end else if (!busy_e && !halted_e && !ifr_e) begin
          run = 0;
        end
        strobe_prev = bus.mem_re | bus.mem_we;
      end
    end
  end

  task automatic wait_pulse(input bit is_fetch, input string nm);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      #1;
      seen = is_fetch ? bus.if_valid : bus.d_done;
      n++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_pulse required=pulse", nm);
    end
  endtask

  task automatic do_fetch(input logic [15:0] a, input logic [15:0] e);
    bexp_t b;
    b.addr = a; b.we = 1'b0; b.wdata = '0;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    if_exp.push_back(e);
    ifb_exp.push_back(b);
    wait_pulse(1'b1, "fetch");
    bus.if_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_data(input bit re, input bit we, input logic [15:0] a,
                         input logic [15:0] wd, input bit hold);
    bexp_t b;
    dexp_t d;
    bus.d_re = re; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    if (we) begin
      d.rd = 1'b0; d.data = '0;
      ref_mem[int'(a)] = wd;
    end else begin
      d.rd = 1'b1; d.data = ref_rd(a);
    end
    b.addr = a; b.we = we; b.wdata = wd;
    d_exp.push_back(d);
    db_exp.push_back(b);
    wait_pulse(1'b0, "data");
    if (!hold) begin
      bus.d_re = 1'b0;
      bus.d_we = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cnt0;
    int bad;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_re = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.halt_req = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_re", 32'(bus.mem_re), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_if_valid", 32'(bus.if_valid), 0);
    chk("rst_d_done", 32'(bus.d_done), 0);
    chk("rst_err_rw", 32'(bus.err_rw), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fetch only, ready three cycles after grant
    lat_fixed = 2;
    mem[16'h0010] = 16'hB123;
    gs = "";
    cnt0 = if_vld_cnt;
    fork
      do_fetch(16'h0010, 16'hB123);
      begin
        @(posedge clk);
        #2;
        chk("t1_mem_re", 32'(bus.mem_re), 1);
        chk("t1_mem_we", 32'(bus.mem_we), 0);
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0010);
      end
    join
    chk("t1_if_valid_count", 32'(if_vld_cnt - cnt0), 1);
    chk("t1_grants", 32'(gs == "F"), 1);
    lat_fixed = -1;

    // Collision: data wins, fetch follows
    gs = "";
    fork
      do_fetch(16'h0020, ref_rd(16'h0020));
      do_data(1'b1, 1'b0, 16'h2000, 16'h0000, 1'b0);
      begin
        @(posedge clk);
        #2;
        chk("t2_mem_re", 32'(bus.mem_re), 1);
        chk("t2_mem_addr", 32'(bus.mem_addr), 32'h2000);
      end
    join
    chk("t2_grants", 32'(gs == "DF"), 1);

    // Starvation bound: four stores, one fetch, stores resume
    gs = "";
    fork
      do_fetch(16'h0040, ref_rd(16'h0040));
      begin
        for (int i = 0; i < 6; i++)
          do_data(1'b0, 1'b1, 16'(16'h1100 + i), 16'($urandom), i < 5);
      end
    join
    checks++;
    if (gs != "DDDDFDD") begin
      failures++;
      $display("FAIL t3_grant_order actual=%s required=DDDDFDD", gs);
    end

    // Randomized traffic
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          logic [15:0] a;
          a = 16'($urandom_range(0, 255));
          do_fetch(a, ref_rd(a));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          bit we;
          bit hold;
          we   = 1'($urandom_range(0, 1));
          hold = (i < 39) && ($urandom_range(0, 1) == 1);
          do_data(!we, we, 16'(16'h1000 + $urandom_range(0, 31)), 16'($urandom), hold);
          if (!hold) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
          end
        end
      end
    join
    chk("rand_err_rw_clear", 32'(bus.err_rw), 0);

    // Read and write together: write wins, error sticks
    gs = "";
    do_data(1'b1, 1'b1, 16'h1300, 16'h00FF, 1'b0);
    chk("t6_err_rw_set", 32'(bus.err_rw), 1);
    do_data(1'b1, 1'b0, 16'h1300, 16'h0000, 1'b0);
    chk("t6_err_rw_sticky", 32'(bus.err_rw), 1);
    chk("t6_grants", 32'(gs == "DD"), 1);

    // Halt during fetch: fetch completes, pending load served, then halted
    fair_chk = 1'b0;
    lat_fixed = 3;
    gs = "";
    fork
      do_fetch(16'h0030, ref_rd(16'h0030));
      begin
        @(posedge clk);
        #2;
        bus.halt_req = 1'b1;
        @(posedge clk);
        #1;
        bus.halt_req = 1'b0;
        do_data(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0);
      end
    join
    lat_fixed = -1;
    chk("t4_grants", 32'(gs == "FD"), 1);
    chk("t4_halted", 32'(bus.halted), 1);
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0050;
    bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.mem_re || bus.mem_we || !bus.halted) bad++;
    end
    chk("t4_halted_ignores_fetch", 32'(bad), 0);
    bus.if_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fair_chk = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_reset_clears_halted", 32'(bus.halted), 0);

    // Reset in the middle of a write
    lat_fixed = 5;
    begin
      bexp_t b;
      b.addr = 16'h1400; b.we = 1'b1; b.wdata = 16'hBEEF;
      db_exp.push_back(b);
    end
    bus.d_we = 1'b1; bus.d_addr = 16'h1400; bus.d_wdata = 16'hBEEF;
    @(posedge clk);
    #1;
    chk("t5_mem_we", 32'(bus.mem_we), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cnt0 = d_done_cnt;
    @(posedge clk);
    #1;
    chk("t5_mem_we_rst", 32'(bus.mem_we), 0);
    chk("t5_mem_re_rst", 32'(bus.mem_re), 0);
    chk("t5_mem_addr_rst", 32'(bus.mem_addr), 0);
    chk("t5_mem_wdata_rst", 32'(bus.mem_wdata), 0);
    chk("t5_d_done_rst", 32'(bus.d_done), 0);
    chk("t5_err_rw_rst", 32'(bus.err_rw), 0);
    chk("t5_if_data_rst", 32'(bus.if_data), 0);
    chk("t5_d_rdata_rst", 32'(bus.d_rdata), 0);
    bus.d_we = 1'b0;
    rst_n = 1'b1;
    lat_fixed = -1;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_done_after_abort", 32'(d_done_cnt - cnt0), 0);

    chk("left_if_exp", 32'(if_exp.size()), 0);
    chk("left_d_exp", 32'(d_exp.size()), 0);
    chk("left_ifb_exp", 32'(ifb_exp.size()), 0);
    chk("left_db_exp", 32'(db_exp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
